uart_tx_arbiter: RTL and testbench

Packet-locked round-robin arbiter that shares the single UART transmit byte path among `N_REQ` requesters, e.g. the loopback echo path, the monitor status reporter and command responders. It sits between the requesters' valid/ready byte streams and the UART transmitter's byte-input handshake inside the UART subsystem. Once a requester is granted, it holds the transmitter until it sends a byte flagged `last`, so multi-byte messages are never interleaved on the line.

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit byte path among N_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the idle-lock watchdog (forced release after TIMEOUT stalled cycles).
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic [N_REQ-1:0]         req_last,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     tx_valid,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_ready,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     timeout_pulse
);
   localparam int GW = $clog2(N_REQ);
   localparam logic [GW:0] N_LIM = (GW+1)'(N_REQ);

   if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 2) begin : g_bad_params
      $error("uart_tx_arbiter: N_REQ must be 2..16 and TIMEOUT >= 2");
   end

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic            busy_q, busy_d;

   logic [DATA_W-1:0] req_bytes [N_REQ];
   logic [N_REQ-1:0]  rot;
   logic [GW-1:0]     off;
   logic [GW:0]       pick_sum;
   logic [GW-1:0]     pick;
   logic              any_req;
   logic [GW:0]       grant_inc;
   logic [GW-1:0]     rr_wrap;
   logic              owner_valid;
   logic              owner_last;
   logic              xfer;
   logic              release_last;
   logic              release_wd;
   logic              wd_expired;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = (state_q == LOCK) && (grant_q == GW'(gi)) && tx_ready;
   end

   assign owner_valid = req_valid[grant_q];
   assign owner_last  = req_last[grant_q];
   assign tx_valid    = (state_q == LOCK) && owner_valid;
   assign tx_data     = (state_q == LOCK) ? req_bytes[grant_q] : '0;
   assign xfer        = tx_valid && tx_ready;

   // Rotate requests so bit 0 is the rr_ptr slot; the lowest set bit is the winner's offset.
   assign rot     = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
   assign any_req = |req_valid;

   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = GW'(k);
      end
   end

   assign pick_sum  = {1'b0, rr_ptr_q} + {1'b0, off};
   assign pick      = (pick_sum >= N_LIM) ? GW'(pick_sum - N_LIM) : pick_sum[GW-1:0];
   assign grant_inc = {1'b0, grant_q} + (GW+1)'(1);
   assign rr_wrap   = (grant_inc == N_LIM) ? '0 : grant_inc[GW-1:0];

   assign release_last = (state_q == LOCK) && xfer && owner_last;
   assign release_wd   = wd_expired && !release_last;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = LOCK;
               grant_d = pick;
               busy_d  = 1'b1;
            end
         end
         LOCK: begin
            if (release_last || release_wd) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               rr_ptr_d = rr_wrap;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            pulse_q;

   // Counter sits at WD_MAX for one cycle; the edge after that forces the release.
   assign wd_expired = (state_q == LOCK) && (wd_q == WD_MAX);

   always_comb begin
      wd_d = wd_q;
      if (state_q != LOCK || xfer) begin
         wd_d = '0;
      end else if (!owner_valid && !wd_expired) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q    <= '0;
         pulse_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         pulse_q <= release_wd;
      end
   end

   assign timeout_pulse = pulse_q;
`else
   assign wd_expired    = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

   assign grant_id = grant_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected (owner, byte) per handshake plus state checks.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            tx_valid;
   logic [DW-1:0]   tx_data;
   logic            tx_ready;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout_pulse;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
      req_valid[i]        = v;
      req_data[i*DW +: DW] = d;
      req_last[i]         = l;
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      sb.push_back(e);
   endtask

   // Handshake monitor: each transfer pops one expected (owner, byte).
   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) begin
         $display("xfer owner=%0d data=0x%02h", grant_id, tx_data);
         n_checks++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed owner=%0d data=0x%02h expected=no transfer", grant_id, tx_data);
         end
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("xfer_owner", 32'(grant_id), mon_e.id);
            chk("xfer_data", 32'(tx_data), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: observed=no finish expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_ready  = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_txv", 32'(tx_valid), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_pulse", 32'(timeout_pulse), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("idle_busy", 32'(busy), 0);

      // Req 2: three-byte packet with tx_ready held high
      tx_ready = 1'b1;
      set_req(2, 1'b1, 8'h41, 1'b0);
      push(2, 8'h41); push(2, 8'h42); push(2, 8'h43);
      #1 chk("t1_idle_txv", 32'(tx_valid), 0);
      step();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_grant", 32'(grant_id), 2);
      chk("t1_txv_c1", 32'(tx_valid), 1);
      chk("t1_ready", 32'(req_ready), 32'h4);
      step();
      set_req(2, 1'b1, 8'h42, 1'b0);
      #1 chk("t1_busy_mid", 32'(busy), 1);
      step();
      set_req(2, 1'b1, 8'h43, 1'b1);
      step();
      set_req(2, 1'b0, 8'h00, 1'b0);
      #1 chk("t1_busy_end", 32'(busy), 0);
      chk("t1_txv_end", 32'(tx_valid), 0);
      chk("t1_drain", 32'(sb.size()), 0);

      // Fresh reset (rr_ptr=0), then all four requesters with single-byte packets
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
      for (int p = 0; p < 5; p++) push(p % N, 8'hA0 + 8'(p % N));
      for (int p = 0; p < 5; p++) begin
         step();
         chk("rr_grant", 32'(grant_id), p % N);
         chk("rr_busy", 32'(busy), 1);
         step();
         chk("rr_bubble_busy", 32'(busy), 0);
         chk("rr_bubble_txv", 32'(tx_valid), 0);
         if (p == 4) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
         end
      end

      // rr_ptr=1: req 1 multi-byte packet while req 0 and req 2 wait
      set_req(1, 1'b1, 8'h11, 1'b0);
      set_req(0, 1'b1, 8'h01, 1'b1);
      set_req(2, 1'b1, 8'h22, 1'b1);
      push(1, 8'h11); push(1, 8'h12); push(1, 8'h13); push(2, 8'h22); push(0, 8'h01);
      step();
      chk("t3_grant1", 32'(grant_id), 1);
      chk("t3_ready", 32'(req_ready), 32'h2);
      step();
      set_req(1, 1'b1, 8'h12, 1'b0);
      step();
      set_req(1, 1'b1, 8'h13, 1'b1);
      step();
      set_req(1, 1'b0, 8'h00, 1'b0);
      #1 chk("t3_release", 32'(busy), 0);
      step();
      chk("t3_grant2", 32'(grant_id), 2);
      step();
      set_req(2, 1'b0, 8'h00, 1'b0);
      step();
      chk("t3_grant0", 32'(grant_id), 0);
      step();
      set_req(0, 1'b0, 8'h00, 1'b0);
      #1 chk("t3_drain", 32'(sb.size()), 0);

      // rr_ptr=1: req 3 stalled by tx_ready=0 for 50 cycles with last pending
      tx_ready = 1'b0;
      set_req(3, 1'b1, 8'h5A, 1'b1);
      push(3, 8'h5A);
      step();
      chk("t4_grant", 32'(grant_id), 3);
      for (int c = 0; c < 50; c++) begin
         step();
         chk("t4_hold_busy", 32'(busy), 1);
         chk("t4_hold_ready", 32'(req_ready), 0);
      end
      tx_ready = 1'b1;
      #1 chk("t4_ready_up", 32'(req_ready), 32'h8);
      step();
      set_req(3, 1'b0, 8'h00, 1'b0);
      #1 chk("t4_release", 32'(busy), 0);
      chk("t4_drain", 32'(sb.size()), 0);

      // Advance rr_ptr to 2, then reset in the middle of a req 2 packet
      set_req(1, 1'b1, 8'h61, 1'b1);
      push(1, 8'h61);
      step();
      chk("t5_pre_grant", 32'(grant_id), 1);
      step();
      set_req(1, 1'b0, 8'h00, 1'b0);
      set_req(2, 1'b1, 8'h62, 1'b0);
      push(2, 8'h62);
      step();
      chk("t5_grant2", 32'(grant_id), 2);
      step();
      tx_ready = 1'b0;
      set_req(2, 1'b1, 8'h63, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_grant", 32'(grant_id), 0);
      chk("t5_rst_txv", 32'(tx_valid), 0);
      set_req(2, 1'b0, 8'h00, 1'b0);
      #1 rst_n = 1'b1;
      set_req(1, 1'b1, 8'h31, 1'b1);
      set_req(3, 1'b1, 8'h33, 1'b1);
      tx_ready = 1'b1;
      push(1, 8'h31); push(3, 8'h33);
      step();
      chk("t5_after_rst", 32'(grant_id), 1);
      step();
      set_req(1, 1'b0, 8'h00, 1'b0);
      step();
      chk("t5_next", 32'(grant_id), 3);
      step();
      set_req(3, 1'b0, 8'h00, 1'b0);
      #1 chk("t5_drain", 32'(sb.size()), 0);

`ifdef UART_ARB_TIMEOUT_EN
      // rr_ptr=0: owner 3 drops valid mid-packet; watchdog releases after TIMEOUT=16
      set_req(3, 1'b1, 8'h90, 1'b0);
      push(3, 8'h90);
      step();
      chk("t6_grant", 32'(grant_id), 3);
      step();
      set_req(3, 1'b0, 8'h00, 1'b0);
      set_req(0, 1'b1, 8'h05, 1'b1);
      for (int c = 0; c < 16; c++) step();
      chk("t6_held_busy", 32'(busy), 1);
      chk("t6_held_pulse", 32'(timeout_pulse), 0);
      step();
      chk("t6_pulse", 32'(timeout_pulse), 1);
      chk("t6_released", 32'(busy), 0);
      push(0, 8'h05);
      step();
      chk("t6_pulse_once", 32'(timeout_pulse), 0);
      chk("t6_grant0", 32'(grant_id), 0);
      step();
      set_req(0, 1'b0, 8'h00, 1'b0);
      #1 chk("t6_end", 32'(busy), 0);
`endif

      step();
      chk("final_drain", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
